// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions: format codes, field positions, immediate limits and the
// offset-opcode range. The decoder must import the same package so both sides agree.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_R    = 2'd0,
        FMT_M    = 2'd1,
        FMT_B    = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_e;

    localparam int WORD_W = 32;
    localparam int OP_W   = 7;
    localparam int REG_W  = 5;

    // Field least-significant bit positions inside the 32-bit word
    localparam int OP_LSB = 25;
    localparam int RD_LSB = 20;
    localparam int RA_LSB = 15;
    localparam int RB_LSB = 10;

    // M keeps offset[14:0] in [14:0]; B splits it into [24:20]=offset[14:10] and [9:0]
    localparam int M_IMM_W    = 15;
    localparam int B_IMM_LO_W = 10;
    localparam int B_IMM_HI_W = 5;

    localparam int OFF_MIN = -16384;
    localparam int OFF_MAX = 16383;

    localparam logic [OP_W-1:0] OP_MEM_LO = 7'h10;
    localparam logic [OP_W-1:0] OP_MEM_HI = 7'h13;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op >= OP_MEM_LO) && (op <= OP_MEM_HI);
    endfunction

    function automatic logic offset_fits(input logic [WORD_W-1:0] off);
        return ($signed(off) >= OFF_MIN) && ($signed(off) <= OFF_MAX);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and extra-bit wrap pointers.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push_rdy drops when full; a pop in the same cycle does not reopen it.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push_rdy = !full;
    assign pop_vld  = !empty;
    // Head reads as zero when empty so downstream never sees stale data
    assign pop_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs and validates instruction fields into 32-bit words for the instruction-memory loader.
// Latency: one cycle from accept to out_valid; rejects pulse err the cycle after accept.
// Backpressure: in_ready follows FIFO-not-full; out_word/out_addr hold while out_ready is low.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [31:0] offset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count
);

    fmt_e              fmt_q;
    logic [WORD_W-1:0] enc_word;
    logic              mem_op;
    logic              off_ok;
    logic              reject;
    logic              accept;
    logic              push;
    logic              fifo_rdy;
    logic              pop;

    assign fmt_q  = fmt_e'(fmt);
    assign mem_op = is_mem_op(op);
    assign off_ok = offset_fits(offset);

    always_comb begin
        enc_word = '0;
        enc_word[OP_LSB +: OP_W] = op;
        case (fmt_q)
            FMT_R: begin
                enc_word[RD_LSB +: REG_W] = rd;
                enc_word[RA_LSB +: REG_W] = ra;
                enc_word[RB_LSB +: REG_W] = rb;
            end
            FMT_M: begin
                enc_word[RD_LSB +: REG_W]  = rd;
                enc_word[RA_LSB +: REG_W]  = ra;
                enc_word[0 +: M_IMM_W]     = offset[M_IMM_W-1:0];
            end
            FMT_B: begin
                enc_word[RD_LSB +: B_IMM_HI_W] = offset[B_IMM_LO_W +: B_IMM_HI_W];
                enc_word[RA_LSB +: REG_W]      = ra;
                enc_word[RB_LSB +: REG_W]      = rb;
                enc_word[0 +: B_IMM_LO_W]      = offset[B_IMM_LO_W-1:0];
            end
            default: ;
        endcase
    end

    // Offset opcodes are legal only in M format, and M format only carries offset opcodes
    always_comb begin
        reject = 1'b1;
        case (fmt_q)
            FMT_R:   reject = mem_op;
            FMT_M:   reject = !mem_op || !off_ok;
            FMT_B:   reject = mem_op || !off_ok;
            default: reject = 1'b1;
        endcase
    end

    assign in_ready = fifo_rdy;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !reject;
    assign pop      = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push),
        .push_rdy (fifo_rdy),
        .push_dat (enc_word),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (out_word)
    );

    // Address advances only on delivery, so rejected requests never consume one
    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr  <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (pop) begin
                out_addr <= out_addr + 32'd4;
            end
            err <= accept && reject;
            if (accept && reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing, rejects, back-pressure and mid-run reset.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .FIFO_DEPTH (4),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .op        (op),
        .rd        (rd),
        .ra        (ra),
        .rb        (rb),
        .offset    (offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [6:0] o, input logic [4:0] d,
                              input logic [4:0] a, input logic [4:0] b, input logic [31:0] off);
        fmt = f; op = o; rd = d; ra = a; rb = b; offset = off;
    endtask

    // Called at a negedge; returns at the next negedge, after the handshake edge
    task automatic send(input logic [1:0] f, input logic [6:0] o, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [31:0] off);
        set_fields(f, o, d, a, b, off);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(2'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_out_word", out_word, 0);

        // R format
        send(2'd0, 7'h01, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("r_valid", out_valid, 1);
        chk("r_word", out_word, 32'h02308800);
        chk("r_addr", out_addr, BASE);
        pop_one();
        chk("r_drained", out_valid, 0);

        // M format, negative offset
        send(2'd1, 7'h10, 5'd5, 5'd2, 5'd0, -32'sd4);
        chk("m_word", out_word, 32'h20517FFC);
        chk("m_addr", out_addr, BASE + 32'd4);
        pop_one();

        // B format, split negative offset
        send(2'd2, 7'h30, 5'd0, 5'd1, 5'd2, -32'sd8);
        chk("b_word", out_word, 32'h61F08BF8);
        chk("b_addr", out_addr, BASE + 32'd8);
        pop_one();

        // Rejects: M offset just over the limit, then offset opcode in R format
        send(2'd1, 7'h10, 5'd5, 5'd2, 5'd0, 32'd16384);
        chk("rej1_err", err, 1);
        chk("rej1_count", err_count, 1);
        chk("rej1_no_word", out_valid, 0);
        send(2'd0, 7'h11, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("rej2_err", err, 1);
        chk("rej2_count", err_count, 2);
        chk("rej2_no_word", out_valid, 0);
        chk("rej2_addr", out_addr, BASE + 32'd12);
        @(negedge clk);
        chk("err_one_cycle", err, 0);

        // Reserved format and M with non-offset opcode
        send(2'd3, 7'h01, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("rej_fmt3_count", err_count, 3);
        send(2'd1, 7'h14, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("rej_mop_count", err_count, 4);
        chk("rej_mop_no_word", out_valid, 0);

        // Offset limits that must be accepted
        send(2'd1, 7'h13, 5'd0, 5'd0, 5'd0, -32'sd16384);
        chk("m_min_err", err, 0);
        chk("m_min_word", out_word, 32'h26004000);
        chk("m_min_addr", out_addr, BASE + 32'd12);
        pop_one();
        send(2'd2, 7'h30, 5'd0, 5'd0, 5'd0, 32'd16383);
        chk("b_max_word", out_word, 32'h60F003FF);
        pop_one();
        chk("b_max_addr_after", out_addr, BASE + 32'd20);

        // Back-pressure: four fit, the fifth is held off
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_before_full", in_ready, 1);
            set_fields(2'd0, 7'h01, 5'(i + 1), 5'd0, 5'd0, 32'd0);
            in_valid = 1'b1;
            @(negedge clk);
        end
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head_word", out_word, 32'h02100000);
        set_fields(2'd0, 7'h01, 5'd5, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("bp_still_full", in_ready, 0);
        chk("bp_word_stable", out_word, 32'h02100000);
        chk("bp_addr_stable", out_addr, BASE + 32'd20);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_word", out_word, {7'h01, 5'(i + 1), 20'h0});
            chk("drain_addr", out_addr, BASE + 32'd20 + 32'(4 * i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_addr_end", out_addr, BASE + 32'd36);

        // Reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            send(2'd0, 7'h02, 5'(i), 5'd0, 5'd0, 32'd0);
        end
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_addr", out_addr, BASE);
        chk("mid_rst_count", err_count, 0);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_emit", out_valid, 0);
        chk("mid_rst_addr_hold", out_addr, BASE);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, first load address after reset.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  instruction fields present.
REQ-007 in_ready  out  1  encoder accepts fields this cycle.
REQ-008 fmt  in  2  format: 0=R, 1=M (offset), 2=B (split offset), 3=reserved.
REQ-009 op  in  7  opcode.
REQ-010 rd, ra, rb  in  5 each  destination, source-A, source-B register numbers.
REQ-011 offset  in  32  signed immediate.
REQ-012 out_valid  out  1  encoded word available.
REQ-013 out_ready  in  1  instruction-memory loader takes word.
REQ-014 out_word  out  32  encoded instruction.
REQ-015 out_addr  out  32  byte address for out_word.
REQ-016 err  out  1  one-cycle pulse when a request is rejected.
REQ-017 err_count  out  8  saturating count of rejected requests.

Function
REQ-018 Packing SHALL be: word[31:25]=op; R: [24:20]=rd, [19:15]=ra, [14:10]=rb, [9:0]=0; M: [24:20]=rd, [19:15]=ra, [14:0]=offset[14:0]; B: [24:20]=offset[14:10], [19:15]=ra, [14:10]=rb, [9:0]=offset[9:0].
REQ-019 A request SHALL be rejected if fmt=3, if offset (M/B) lies outside -16384..16383, or if op in 7'h10..7'h13 and fmt is not M, or if fmt=M and op is outside 7'h10..7'h13.
REQ-020 in_ready SHALL equal "FIFO not full"; handshake = in_valid and in_ready.
REQ-021 An accepted valid request SHALL be enqueued; a rejected one SHALL be consumed, not enqueued, pulse err next cycle, and increment err_count (saturate at 255).
REQ-022 out_valid SHALL equal "FIFO not empty"; out_word and out_addr are the head entry; minimum latency from accept to out_valid is 1 cycle.
REQ-023 out_addr SHALL start at BASE_ADDR and advance by 4 on each out handshake, wrapping modulo 2^32.
REQ-024 out_word/out_addr SHALL remain stable while out_valid and not out_ready.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; when full, a same-cycle pop does not enable push (in_ready stays low that cycle).
REQ-026 Rejected requests SHALL not consume an address.
REQ-027 Order of out words SHALL equal order of accepted valid requests.

Reset
REQ-028 On reset: FIFO empty, out_valid=0, in_ready=1 the cycle after, out_addr=BASE_ADDR, err=0, err_count=0, out_word=0.
REQ-029 Reset mid-operation SHALL discard all buffered words without emitting them.

Structure
REQ-030 Format codes, field bit positions, offset limits and the 7'h10..7'h13 offset-opcode range SHALL live in a shared ISA package also used by the decoder.
REQ-031 The buffer SHALL be a sub-module sync_fifo (width 32, depth FIFO_DEPTH); packing and checking stay combinational in instr_encoder.

Verification
REQ-032 R: op=7'h01, rd=3, ra=1, rb=2 -> out_word=32'h02308800, out_addr=BASE_ADDR.
REQ-033 M: op=7'h10, rd=5, ra=2, offset=-4 -> out_word=32'h20517FFC at BASE_ADDR+4.
REQ-034 B: op=7'h30, ra=1, rb=2, offset=-8 -> out_word=32'h61F08BF8.
REQ-035 Rejects: M op=7'h10 offset=16384, then R op=7'h11 -> two err pulses, err_count=2, no words, out_addr unchanged.
REQ-036 Back-pressure: out_ready=0, push 5 requests -> in_ready low after 4, words stable; release -> all 4 emitted in order, addresses +4 each.
REQ-037 Reset asserted with 3 words buffered -> out_valid=0, out_addr=BASE_ADDR, err_count=0 next cycle.
